// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared M-extension encodings and issue FSM state type
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    WB     = 3'd4
  } state_e;

  // True for an R-type OP word carrying the MULDIV funct7.
  function automatic logic is_muldiv(input logic [31:0] word);
    return (word[6:0] == OPC_OP) && (word[31:25] == F7_MULDIV);
  endfunction

endpackage

// File: rtl/rv32m_issue_if.sv
// rtl/rv32m_issue_if.sv - instruction, rv32m and writeback signal bundle
interface rv32m_issue_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        m_rst;
  logic        m_in_valid;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic [2:0]  m_funct3;
  logic        m_out_valid;
  logic        m_in_error;
  logic [31:0] m_rd;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        illegal;

  // Sequencer side.
  modport slave (
    input  instr_valid, instr, rs1_data, rs2_data,
    input  m_out_valid, m_in_error, m_rd,
    input  wb_ready,
    output instr_ready,
    output m_rst, m_in_valid, m_rs1, m_rs2, m_funct3,
    output wb_valid, wb_idx, wb_data, wb_err, illegal
  );

  // Environment side: issuer, rv32m and register file.
  modport master (
    output instr_valid, instr, rs1_data, rs2_data,
    output m_out_valid, m_in_error, m_rd,
    output wb_ready,
    input  instr_ready,
    input  m_rst, m_in_valid, m_rs1, m_rs2, m_funct3,
    input  wb_valid, wb_idx, wb_data, wb_err, illegal
  );

endinterface

// File: rtl/rv32m_special.sv
// rtl/rv32m_special.sv - RISC-V divide special-case resolver (pure combinational)
module rv32m_special
  import rv32m_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        hit,
  output logic [31:0] value
);

  logic div_zero;
  logic div_ovf;

  assign div_zero = (rs2 == 32'h0000_0000);
  assign div_ovf  = (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  // Architecturally defined results for divide-by-zero and signed overflow.
  always_comb begin
    hit   = 1'b0;
    value = 32'h0000_0000;
    case (funct3)
      F3_DIV: begin
        if (div_zero) begin
          hit   = 1'b1;
          value = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          hit   = 1'b1;
          value = 32'h8000_0000;
        end
      end
      F3_DIVU: begin
        if (div_zero) begin
          hit   = 1'b1;
          value = 32'hFFFF_FFFF;
        end
      end
      F3_REM: begin
        if (div_zero) begin
          hit   = 1'b1;
          value = rs1;
        end else if (div_ovf) begin
          hit   = 1'b1;
          value = 32'h0000_0000;
        end
      end
      F3_REMU: begin
        if (div_zero) begin
          hit   = 1'b1;
          value = rs1;
        end
      end
      default: begin
        hit   = 1'b0;
        value = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/rv32m_issue.sv
// rtl/rv32m_issue.sv - issue/writeback sequencer in front of the rv32m unit
module rv32m_issue
  import rv32m_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  rv32m_issue_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic          legal_q, legal_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_err_q, wb_err_d;

  logic          sp_hit;
  logic [31:0]   sp_value;
  logic          rd_zero;

  assign rd_zero = (rd_q == 5'd0);

  // Special cases are judged on the latched operands while in CLR.
  rv32m_special u_special (
    .funct3 (f3_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .hit    (sp_hit),
    .value  (sp_value)
  );

  // Next-state, operand latching, timeout counting and writeback capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    legal_d   = legal_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          rd_d    = bus.instr[11:7];
          f3_d    = bus.instr[14:12];
          rs1_d   = bus.rs1_data;
          rs2_d   = bus.rs2_data;
          legal_d = is_muldiv(bus.instr);
          state_d = CLR;
        end
      end
      CLR: begin
        if (!legal_q || rd_zero) begin
          state_d = IDLE;
        end else if (sp_hit) begin
          wb_data_d = sp_value;
          wb_err_d  = 1'b0;
          state_d   = WB;
        end else begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle still wins.
        if (bus.m_out_valid) begin
          wb_data_d = bus.m_rd;
          wb_err_d  = bus.m_in_error;
          state_d   = WB;
        end else if (cnt_q == CNT_LAST) begin
          wb_data_d = 32'h0000_0000;
          wb_err_d  = 1'b1;
          state_d   = WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        if (bus.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 5'd0;
      f3_q      <= 3'd0;
      rs1_q     <= 32'h0000_0000;
      rs2_q     <= 32'h0000_0000;
      legal_q   <= 1'b0;
      wb_data_q <= 32'h0000_0000;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      legal_q   <= legal_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.m_rst       = (state_q == CLR) && legal_q && !rd_zero && !sp_hit;
  assign bus.m_in_valid  = (state_q == LAUNCH);
  assign bus.m_rs1       = rs1_q;
  assign bus.m_rs2       = rs2_q;
  assign bus.m_funct3    = f3_q;
  assign bus.illegal     = (state_q == CLR) && !legal_q;
  assign bus.wb_valid    = (state_q == WB);
  assign bus.wb_idx      = rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_rv32m_issue.sv
// tb/tb_rv32m_issue.sv - scoreboard bench for rv32m_issue with a behavioural rv32m
module tb_rv32m_issue;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
  } wb_exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   n_launch;
  int   n_mrst;
  int   model_delay;
  logic model_silent;
  wb_exp_t sb_q[$];

  rv32m_issue_if ifc ();

  rv32m_issue #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic push(input logic [4:0] idx, input logic [31:0] data, input logic err);
    wb_exp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!ifc.instr_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ifc.instr_ready) check("issue_ready_timeout", ifc.instr_ready, 1);
    ifc.instr_valid = 1'b1;
    ifc.instr       = ins;
    ifc.rs1_data    = a;
    ifc.rs2_data    = b;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    ifc.instr       = $urandom;
    ifc.rs1_data    = $urandom;
    ifc.rs2_data    = $urandom;
  endtask

  task automatic wait_wb(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ifc.wb_valid && k < 40);
    if (!ifc.wb_valid) check("wb_wait_timeout", ifc.wb_valid, 1);
  endtask

  // Behavioural rv32m: answers MUL low word model_delay cycles after launch.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] opa, opb;
    pend = 1'b0;
    cnt  = 0;
    opa  = 0;
    opb  = 0;
    ifc.m_out_valid = 1'b0;
    ifc.m_in_error  = 1'b0;
    ifc.m_rd        = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      if (ifc.m_rst) n_mrst++;
      if (ifc.m_in_valid) begin
        n_launch++;
        if (!model_silent) begin
          pend = 1'b1;
          cnt  = model_delay;
          opa  = ifc.m_rs1;
          opb  = ifc.m_rs2;
        end
      end
      @(posedge clk); #1;
      ifc.m_out_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          ifc.m_out_valid = 1'b1;
          ifc.m_rd        = opa * opb;
          pend            = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted writeback beat is matched in order.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.wb_valid && ifc.wb_ready) begin
        if (sb_q.size() == 0) begin
          check("wb_unexpected", ifc.wb_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("wb_idx", ifc.wb_idx, e.idx);
          check("wb_data", ifc.wb_data, e.data);
          check("wb_err", ifc.wb_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, l0, r0;
    n_vec = 0;
    n_err = 0;
    n_launch = 0;
    n_mrst = 0;
    model_delay = 2;
    model_silent = 1'b0;
    rst = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.instr = 32'h0;
    ifc.rs1_data = 32'h0;
    ifc.rs2_data = 32'h0;
    ifc.wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_instr_ready", ifc.instr_ready, 1);
    check("rst_m_rst", ifc.m_rst, 0);
    check("rst_m_in_valid", ifc.m_in_valid, 0);
    check("rst_wb_valid", ifc.wb_valid, 0);
    check("rst_wb_err", ifc.wb_err, 0);
    check("rst_illegal", ifc.illegal, 0);
    check("rst_m_rs1", ifc.m_rs1, 0);
    check("rst_m_rs2", ifc.m_rs2, 0);
    check("rst_m_funct3", ifc.m_funct3, 0);
    check("rst_wb_idx", ifc.wb_idx, 0);
    check("rst_wb_data", ifc.wb_data, 0);

    // MUL 3*7, rd=5, rv32m answers two cycles after launch
    l0 = n_launch; r0 = n_mrst;
    push(5'd5, 32'd21, 1'b0);
    issue(mk(3'b000, 5'd5), 32'd3, 32'd7);
    wait_wb(k);
    check("mul_latency", k, 5);
    check("mul_m_rs1", ifc.m_rs1, 32'd3);
    check("mul_m_rs2", ifc.m_rs2, 32'd7);
    check("mul_m_funct3", ifc.m_funct3, 3'b000);
    check("mul_launches", n_launch - l0, 1);
    check("mul_m_rst", n_mrst - r0, 1);

    // DIVU by zero, rd=1
    l0 = n_launch; r0 = n_mrst;
    push(5'd1, 32'hFFFF_FFFF, 1'b0);
    issue(mk(3'b101, 5'd1), 32'd1234, 32'd0);
    wait_wb(k);
    check("divu0_latency", k, 2);
    check("divu0_launches", n_launch - l0, 0);
    check("divu0_m_rst", n_mrst - r0, 0);

    // REM overflow, rd=7
    push(5'd7, 32'h0, 1'b0);
    issue(mk(3'b110, 5'd7), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_wb(k);
    check("removf_latency", k, 2);

    // DIV overflow, rd=8
    push(5'd8, 32'h8000_0000, 1'b0);
    issue(mk(3'b100, 5'd8), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_wb(k);
    check("divovf_latency", k, 2);

    // REMU by zero, rd=9
    l0 = n_launch;
    push(5'd9, 32'h0000_1234, 1'b0);
    issue(mk(3'b111, 5'd9), 32'h0000_1234, 32'd0);
    wait_wb(k);
    check("remu0_latency", k, 2);
    check("remu0_launches", n_launch - l0, 0);

    // ADD (funct7=0) is rejected
    l0 = n_launch; r0 = n_mrst;
    issue(32'h0020_8033, 32'd5, 32'd6);
    @(negedge clk);
    check("ill_pulse", ifc.illegal, 1);
    check("ill_busy", ifc.instr_ready, 0);
    check("ill_no_wb1", ifc.wb_valid, 0);
    @(negedge clk);
    check("ill_pulse_end", ifc.illegal, 0);
    check("ill_ready_back", ifc.instr_ready, 1);
    check("ill_no_wb2", ifc.wb_valid, 0);
    check("ill_launches", n_launch - l0, 0);
    check("ill_m_rst", n_mrst - r0, 0);

    // rv32m never answers: timeout after 8 WAIT cycles
    l0 = n_launch;
    model_silent = 1'b1;
    push(5'd3, 32'h0, 1'b1);
    issue(mk(3'b000, 5'd3), 32'd9, 32'd9);
    wait_wb(k);
    check("tmo_latency", k, 11);
    check("tmo_launches", n_launch - l0, 1);
    model_silent = 1'b0;

    // Writeback stalled for 5 cycles
    @(posedge clk); #1;
    ifc.wb_ready = 1'b0;
    push(5'd4, 32'hFFFF_FFFF, 1'b0);
    issue(mk(3'b101, 5'd4), 32'd77, 32'd0);
    wait_wb(k);
    check("stall_latency", k, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_wb_valid", ifc.wb_valid, 1);
      check("stall_wb_idx", ifc.wb_idx, 5'd4);
      check("stall_wb_data", ifc.wb_data, 32'hFFFF_FFFF);
      check("stall_wb_err", ifc.wb_err, 0);
      check("stall_instr_ready", ifc.instr_ready, 0);
    end
    @(posedge clk); #1;
    ifc.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_release_ready", ifc.instr_ready, 1);
    check("stall_release_wb", ifc.wb_valid, 0);

    // MULHU with rd=x0: dropped silently
    l0 = n_launch; r0 = n_mrst;
    issue(mk(3'b011, 5'd0), 32'd5, 32'd6);
    @(negedge clk);
    check("x0_illegal", ifc.illegal, 0);
    check("x0_no_wb1", ifc.wb_valid, 0);
    @(negedge clk);
    check("x0_ready_back", ifc.instr_ready, 1);
    check("x0_no_wb2", ifc.wb_valid, 0);
    check("x0_launches", n_launch - l0, 0);
    check("x0_m_rst", n_mrst - r0, 0);

    // Reset while in WAIT
    model_silent = 1'b1;
    issue(mk(3'b000, 5'd6), 32'd1, 32'd2);
    repeat (3) @(negedge clk);
    check("abort_in_wait", ifc.m_in_valid | ifc.wb_valid | ifc.instr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_instr_ready", ifc.instr_ready, 1);
    check("abort_m_rst", ifc.m_rst, 0);
    check("abort_m_in_valid", ifc.m_in_valid, 0);
    check("abort_wb_valid", ifc.wb_valid, 0);
    check("abort_wb_err", ifc.wb_err, 0);
    check("abort_illegal", ifc.illegal, 0);
    check("abort_m_rs1", ifc.m_rs1, 0);
    check("abort_m_rs2", ifc.m_rs2, 0);
    check("abort_wb_idx", ifc.wb_idx, 0);
    check("abort_wb_data", ifc.wb_data, 0);
    model_silent = 1'b0;

    // MUL 0xFFFFFFFF * 2 after the abort
    push(5'd10, 32'hFFFF_FFFE, 1'b0);
    issue(mk(3'b000, 5'd10), 32'hFFFF_FFFF, 32'd2);
    wait_wb(k);
    check("mul2_latency", k, 5);

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
